// File: rtl/spi_master.sv
// SPI master, mode 0, LSB first, one SS frame per byte.
// Optional MISO capture is built only with SPI_MASTER_RX_EN.
module spi_master #(
  parameter int CLK_DIV    = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       SCK,
  output logic       SS,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    IDLE, LEAD, HIGH, LOW, GAP
  } state_t;

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_M1 = 8'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic       sck_q, sck_d;
  logic       ss_q, ss_d;
  logic       mosi_q, mosi_d;
  logic       half_done;
  logic       in_frame;
  logic       rise_now;

  assign half_done = (cnt_q == DIV_M1);
  assign in_frame  = (state_q == LEAD) || (state_q == HIGH)
                  || (state_q == LOW);
  assign rise_now  = (state_q == HIGH) && (cnt_q == 8'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    bit_d   = bit_q;
    tx_sh_d = tx_sh_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (tx_valid) begin
          state_d = LEAD;
          tx_sh_d = tx_data;
          bit_d   = 3'd0;
        end
      end
      LEAD: begin
        if (half_done) begin
          state_d = HIGH;
          cnt_d   = 8'd0;
        end
      end
      HIGH: begin
        if (half_done) begin
          cnt_d = 8'd0;
          if (bit_q == 3'd7) begin
            state_d = GAP;
          end else begin
            state_d = LOW;
            tx_sh_d = {1'b1, tx_sh_q[7:1]};
          end
        end
      end
      LOW: begin
        if (half_done) begin
          state_d = HIGH;
          cnt_d   = 8'd0;
          bit_d   = bit_q + 3'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_M1) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Pins are registered from the state, so they trail it by one clk.
  always_comb begin
    sck_d  = (state_q == HIGH);
    ss_d   = !in_frame;
    mosi_d = in_frame ? tx_sh_q[0] : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 3'd0;
      tx_sh_q <= 8'd0;
      sck_q   <= 1'b0;
      ss_q    <= 1'b1;
      mosi_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_sh_q <= tx_sh_d;
      sck_q   <= sck_d;
      ss_q    <= ss_d;
      mosi_q  <= mosi_d;
    end
  end

`ifdef SPI_MASTER_RX_EN
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_end;

  assign frame_end = (state_q == GAP) && (cnt_q == 8'd0);

  always_comb begin
    rx_sh_d    = rise_now ? {MISO, rx_sh_q[7:1]} : rx_sh_q;
    rx_data_d  = frame_end ? rx_sh_q : rx_data_q;
    rx_valid_d = frame_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sh_q    <= 8'd0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
`else
  logic unused_rx;
  assign unused_rx = MISO ^ rise_now;
  assign rx_data   = 8'h00;
  assign rx_valid  = 1'b0;
`endif

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign SCK      = sck_q;
  assign SS       = ss_q;
  assign MOSI     = mosi_q;

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 8: clk cycles per SCK half-period; legal values 2..255.
REQ-002 SHALL have parameter GAP_CYCLES, default 4: clk cycles SS stays high after a byte before tx_ready reasserts; legal values 1..255.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port tx_data, input, 8 bits: byte to transmit, LSB first.
REQ-006 SHALL have port tx_valid, input, 1 bit: tx_data valid.
REQ-007 SHALL have port tx_ready, output, 1 bit: block can accept a byte.
REQ-008 SHALL have port rx_data, output, 8 bits: last byte captured from MISO.
REQ-009 SHALL have port rx_valid, output, 1 bit: one-cycle strobe, rx_data updated.
REQ-010 SHALL have port busy, output, 1 bit: high while a byte frame or gap is in progress.
REQ-011 SHALL have port SCK, output, 1 bit: serial clock, idle low.
REQ-012 SHALL have port SS, output, 1 bit: slave select, active low, asserted per byte.
REQ-013 SHALL have port MOSI, output, 1 bit: serial data out, idle high.
REQ-014 SHALL have port MISO, input, 1 bit: serial data in.

Function
REQ-015 SHALL implement states IDLE, LEAD, HIGH, LOW, GAP; only IDLE drives tx_ready=1, and busy = not IDLE.
REQ-016 Accept SHALL occur on an edge where tx_valid and tx_ready are both 1; tx_data is latched and later changes to tx_data are ignored.
REQ-017 After an accept at edge k, from edge k+1 the block SHALL drive SS=0, SCK=0 and MOSI=tx_data[0] (state LEAD).
REQ-018 SCK rising edge n (n=0..7) SHALL occur at edge k+1+CLK_DIV*(1+2n); falling edge n SHALL occur at edge k+1+CLK_DIV*(2+2n).
REQ-019 MISO SHALL be sampled into rx shift bit n on the same edge SCK rises for bit n, LSB first.
REQ-020 MOSI SHALL change to bit n+1 only on the edge of SCK falling edge n, for n<7, and SHALL never change while SCK=1.
REQ-021 On falling edge 7 the block SHALL drive SS=1 and MOSI=1 and pulse rx_valid for exactly one cycle with rx_data updated; SS is low for exactly 16*CLK_DIV cycles.
REQ-022 The GAP state SHALL last GAP_CYCLES cycles, after which the block SHALL enter IDLE with tx_ready=1.
REQ-023 With tx_valid held high, back-to-back bytes SHALL keep SS high for exactly GAP_CYCLES+1 cycles between frames.
REQ-024 tx_valid while busy SHALL be ignored with no effect on the frame in progress.
REQ-025 The half-period counter and bit counter SHALL wrap cleanly, with no extra or missing SCK pulses at any CLK_DIV in range.

Reset
REQ-026 With rst=1 at an edge the block SHALL enter IDLE and drive SS=1, SCK=0, MOSI=1, tx_ready=1, busy=0, rx_valid=0, rx_data=0x00.
REQ-027 A reset asserted mid-frame SHALL abort the frame on that edge with no partial rx_valid, and the next accepted byte SHALL start a full frame.

Configuration
REQ-028 With macro SPI_MASTER_RX_EN defined, MISO capture, rx_data and rx_valid SHALL operate as specified above.
REQ-029 Without SPI_MASTER_RX_EN, MISO SHALL be ignored and rx_data SHALL be constant 0x00 and rx_valid constant 0; all TX timing SHALL be unchanged.

Verification
REQ-030 Reset then idle, CLK_DIV=8, GAP_CYCLES=4 -> SS=1, SCK=0, MOSI=1, tx_ready=1, busy=0, with no SCK toggles for 200 cycles.
REQ-031 Send 0xA5 with MISO looped to MOSI -> MOSI sequence at SCK rises is 1,0,1,0,0,1,0,1; exactly 8 SCK pulses; SS low for 128 cycles; rx_data=0xA5 with a single rx_valid pulse.
REQ-032 Send 0x00 then 0xFF with tx_valid held -> SS high gap between frames is 5 cycles; rx_valid pulses exactly twice; tx_ready low throughout each frame.
REQ-033 rst pulsed at SCK rise 3 of a 0x3C frame -> next edge SS=1, SCK=0, no rx_valid; following 0x81 frame transmits correctly.
REQ-034 CLK_DIV=2 with 0x5A -> SCK period 4 cycles; SS low 32 cycles; MOSI stable across every SCK high phase.
REQ-035 SPI_MASTER_RX_EN undefined with MISO toggling randomly and 0xA5 sent -> rx_data=0x00, rx_valid never 1, MOSI/SCK/SS timing identical to REQ-031.
